// File: rtl/mac_array_sequencer_pkg.sv
// Shared constants for the MAC array sequencer: opcodes, FSM encoding, status layout.
package mac_array_sequencer_pkg;

  localparam logic [31:0] INST_COMPUTE    = 32'd87;
  localparam logic [31:0] INST_LOADIFMAPS = 32'd88;
  localparam logic [31:0] INST_CLEAR      = 32'd0;

  localparam logic [4:0] KERNEL_MAX = 5'd5;

  localparam int ST_DONE_BIT  = 0;
  localparam int ST_BUSY_BIT  = 1;
  localparam int ST_ERR_BIT   = 2;
  localparam int ST_PERF_LSB  = 8;
  localparam int ST_BEATS_LSB = 16;

  typedef enum logic [2:0] {
    IDLE, LOAD_WT, COMMIT, COMPUTE, DRAIN, DONE
  } seq_state_e;

  function automatic logic k_legal(input logic [4:0] k);
    return (k != 5'd0) && (k <= KERNEL_MAX);
  endfunction

endpackage

// File: rtl/mac_seq_weight_fetch.sv
// Weight-row fetch: walks K BRAM rows from base and emits the preload pulse one
// cycle behind each read enable (1-cycle BRAM latency).
module mac_seq_weight_fetch #(
  parameter int BRAM_ADDRESS_WIDTH = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          active,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] base,
  input  logic [4:0]                    k,
  output logic [BRAM_ADDRESS_WIDTH-1:0] addr,
  output logic                          en,
  output logic                          preload,
  output logic                          fetch_done
);

  logic [2:0] row;
  logic       last_q;

  assign en         = active && ({2'b00, row} < k);
  // Address wraps naturally at the BRAM width; parked at 0 when idle.
  assign addr       = en ? base + BRAM_ADDRESS_WIDTH'(row) : '0;
  assign fetch_done = last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row     <= '0;
      preload <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      preload <= en;
      last_q  <= en && ({2'b00, row} == k - 5'd1);
      if (!active)  row <= '0;
      else if (en)  row <= row + 3'd1;
    end
  end

endmodule

// File: rtl/mac_array_sequencer.sv
// Sequences one MAC array pass: weight fetch, commit, ifmap streaming, drain.
// Define MAC_SEQ_PERF_CNT_EN to enable the FIFO-starvation counter in status[15:8].
module mac_array_sequencer
  import mac_array_sequencer_pkg::*;
#(
  parameter int BRAM_ADDRESS_WIDTH = 12,
  parameter int COUNT_WIDTH        = 16,
  parameter int DRAIN_CYCLES       = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   inst,
  input  logic                          inst_valid,
  input  logic [4:0]                    cfg_kernel_size,
  input  logic                          cfg_operation,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] cfg_weight_base,
  input  logic [COUNT_WIDTH-1:0]        cfg_ifmap_count,
  input  logic                          ifmaps_fifo_empty,
  output logic [BRAM_ADDRESS_WIDTH-1:0] weight_bram_addr,
  output logic                          weight_bram_en,
  output logic                          load_weight_preload,
  output logic                          load_MAC_weight,
  output logic                          load_ifmaps,
  output logic                          operation,
  output logic [4:0]                    kernel_size,
  output logic                          busy,
  output logic [31:0]                   status
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  seq_state_e state, state_nxt;

  logic [4:0]                    k_q;
  logic                          op_q;
  logic [BRAM_ADDRESS_WIDTH-1:0] base_q;
  logic [COUNT_WIDTH-1:0]        count_q;
  logic [COUNT_WIDTH-1:0]        beats;
  logic [DW-1:0]                 drain_cnt;
  logic                          err_q;
  logic [7:0]                    perf;
  logic                          fetch_done;

  logic accept, do_compute, do_loadif, do_clear, k_ok, beats_left;

  assign accept     = inst_valid && (state == IDLE || state == DONE);
  assign do_compute = accept && (inst == INST_COMPUTE);
  assign do_loadif  = accept && (inst == INST_LOADIFMAPS);
  assign do_clear   = accept && (inst == INST_CLEAR);
  assign k_ok       = k_legal(cfg_kernel_size);
  assign beats_left = beats < count_q;

  assign load_ifmaps     = (state == COMPUTE) && beats_left && !ifmaps_fifo_empty;
  assign load_MAC_weight = (state == COMMIT);
  assign busy            = (state != IDLE) && (state != DONE);
  assign operation       = op_q;
  assign kernel_size     = k_q;

  mac_seq_weight_fetch #(
    .BRAM_ADDRESS_WIDTH(BRAM_ADDRESS_WIDTH)
  ) u_fetch (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (state == LOAD_WT),
    .base      (base_q),
    .k         (k_q),
    .addr      (weight_bram_addr),
    .en        (weight_bram_en),
    .preload   (load_weight_preload),
    .fetch_done(fetch_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (do_compute)     state_nxt = k_ok ? LOAD_WT : DONE;
        else if (do_loadif) state_nxt = COMPUTE;
        else if (do_clear)  state_nxt = IDLE;
      end
      LOAD_WT: if (fetch_done) state_nxt = COMMIT;
      COMMIT:  state_nxt = COMPUTE;
      // Leave on the cycle of the final pop so no extra beat can slip out.
      COMPUTE: if (!beats_left || (load_ifmaps && (beats + COUNT_WIDTH'(1) == count_q)))
                 state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DW'(DRAIN_CYCLES - 1)) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q       <= '0;
      op_q      <= 1'b0;
      base_q    <= '0;
      count_q   <= '0;
      beats     <= '0;
      drain_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      if ((do_compute && k_ok) || do_loadif) begin
        k_q     <= cfg_kernel_size;
        op_q    <= cfg_operation;
        base_q  <= cfg_weight_base;
        count_q <= cfg_ifmap_count;
        beats   <= '0;
        err_q   <= 1'b0;
      end else if (do_compute) begin
        beats   <= '0;
        err_q   <= 1'b1;
      end else if (do_clear) begin
        beats   <= '0;
        err_q   <= 1'b0;
      end else if (load_ifmaps && beats != '1) begin
        beats   <= beats + COUNT_WIDTH'(1);
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
    end
  end

`ifdef MAC_SEQ_PERF_CNT_EN
  logic [7:0] perf_q;
  always_ff @(posedge clk) begin
    if (!rst_n)
      perf_q <= '0;
    else if (do_compute || do_loadif || do_clear)
      perf_q <= '0;
    else if (state == COMPUTE && ifmaps_fifo_empty && beats_left && perf_q != 8'hFF)
      perf_q <= perf_q + 8'd1;
  end
  assign perf = perf_q;
`else
  assign perf = '0;
`endif

  always_comb begin
    status                                = '0;
    status[ST_DONE_BIT]                   = (state == DONE);
    status[ST_BUSY_BIT]                   = busy;
    status[ST_ERR_BIT]                    = err_q;
    status[ST_PERF_LSB +: 8]              = perf;
    status[ST_BEATS_LSB +: 16]            = 16'(beats);
  end

endmodule

// File: tb/tb_mac_array_sequencer.sv
// Directed self-checking bench for mac_array_sequencer.
module tb_mac_array_sequencer;
  import mac_array_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        inst_valid;
  logic [4:0]  cfg_kernel_size;
  logic        cfg_operation;
  logic [11:0] cfg_weight_base;
  logic [15:0] cfg_ifmap_count;
  logic        ifmaps_fifo_empty;
  logic [11:0] weight_bram_addr;
  logic        weight_bram_en, load_weight_preload, load_MAC_weight, load_ifmaps;
  logic        operation, busy;
  logic [4:0]  kernel_size;
  logic [31:0] status;

  int tests = 0;
  int fails = 0;

`ifdef MAC_SEQ_PERF_CNT_EN
  localparam logic [7:0] EXP_PERF = 8'd3;
`else
  localparam logic [7:0] EXP_PERF = 8'd0;
`endif

  mac_array_sequencer dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .inst_valid(inst_valid),
    .cfg_kernel_size(cfg_kernel_size), .cfg_operation(cfg_operation),
    .cfg_weight_base(cfg_weight_base), .cfg_ifmap_count(cfg_ifmap_count),
    .ifmaps_fifo_empty(ifmaps_fifo_empty), .weight_bram_addr(weight_bram_addr),
    .weight_bram_en(weight_bram_en), .load_weight_preload(load_weight_preload),
    .load_MAC_weight(load_MAC_weight), .load_ifmaps(load_ifmaps),
    .operation(operation), .kernel_size(kernel_size), .busy(busy), .status(status)
  );

  always #5 clk = ~clk;

  // per-run trace, filled by run_trace
  int          en_n, pre_n, mac_n, if_n, pop_empty_n, busy_low_n, done_cyc;
  int          mac_cyc, if_first, if_last, done_busy;
  int          en_cyc[8];
  int          pre_cyc[8];
  logic [11:0] addrs[8];
  logic [31:0] done_status;

  task automatic issue(input logic [31:0] op, input logic [4:0] k, input logic opsel,
                       input logic [11:0] base, input logic [15:0] cnt);
    inst = op; cfg_kernel_size = k; cfg_operation = opsel;
    cfg_weight_base = base; cfg_ifmap_count = cnt; inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    // scramble config so the DUT must rely on its latched copy
    cfg_kernel_size = 5'd7; cfg_operation = ~opsel;
    cfg_weight_base = ~base; cfg_ifmap_count = cnt + 16'd3;
  endtask

  task automatic run_trace(input int maxc, input logic [63:0] empty_mask,
                           input int inj_cyc, input logic [31:0] inj_inst);
    en_n = 0; pre_n = 0; mac_n = 0; if_n = 0; pop_empty_n = 0; busy_low_n = 0;
    done_cyc = -1; mac_cyc = -1; if_first = -1; if_last = -1; done_busy = -1;
    done_status = '0;
    for (int i = 0; i < maxc; i++) begin
      ifmaps_fifo_empty = empty_mask[i];
      inst_valid = (i == inj_cyc);
      inst = inj_inst;
      #1;
      if (weight_bram_en) begin
        if (en_n < 8) begin en_cyc[en_n] = i; addrs[en_n] = weight_bram_addr; end
        en_n++;
      end
      if (load_weight_preload) begin
        if (pre_n < 8) pre_cyc[pre_n] = i;
        pre_n++;
      end
      if (load_MAC_weight) begin mac_n++; mac_cyc = i; end
      if (load_ifmaps) begin
        if_n++;
        if (if_first < 0) if_first = i;
        if_last = i;
        if (ifmaps_fifo_empty) pop_empty_n++;
      end
      if (status[0]) begin
        done_cyc = i; done_status = status; done_busy = int'(busy);
        break;
      end
      if (!busy) busy_low_n++;
      @(posedge clk); #1;
    end
    inst_valid = 1'b0;
    ifmaps_fifo_empty = 1'b0;
    tests++;
    if (done_cyc < 0) begin
      fails++;
      $display("FAIL run_timeout: done not seen within %0d cycles", maxc);
    end
  endtask

  task automatic test_reset();
    tests++; if (status !== 32'h0) begin fails++; $display("FAIL reset_status: got %h exp 0", status); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
    tests++; if ({weight_bram_en, load_weight_preload, load_MAC_weight, load_ifmaps} !== 4'b0)
      begin fails++; $display("FAIL reset_strobes: got %b exp 0000",
        {weight_bram_en, load_weight_preload, load_MAC_weight, load_ifmaps}); end
    tests++; if ({weight_bram_addr, operation, kernel_size} !== 18'h0)
      begin fails++; $display("FAIL reset_regs: got %h exp 0", {weight_bram_addr, operation, kernel_size}); end
  endtask

  task automatic test_compute();
    issue(INST_COMPUTE, 5'd3, 1'b1, 12'h010, 16'd8);
    run_trace(40, 64'h0, -1, 32'h0);
    tests++; if (en_n !== 3) begin fails++; $display("FAIL cmp_en_count: got %0d exp 3", en_n); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (addrs[i] !== 12'h010 + 12'(i))
        begin fails++; $display("FAIL cmp_addr%0d: got %h exp %h", i, addrs[i], 12'h010 + 12'(i)); end
      tests++; if (en_cyc[i] !== i)
        begin fails++; $display("FAIL cmp_en_cyc%0d: got %0d exp %0d", i, en_cyc[i], i); end
      tests++; if (pre_cyc[i] !== i + 1)
        begin fails++; $display("FAIL cmp_pre_cyc%0d: got %0d exp %0d", i, pre_cyc[i], i + 1); end
    end
    tests++; if (pre_n !== 3) begin fails++; $display("FAIL cmp_pre_count: got %0d exp 3", pre_n); end
    tests++; if (mac_n !== 1 || mac_cyc !== 4)
      begin fails++; $display("FAIL cmp_commit: got n=%0d cyc=%0d exp n=1 cyc=4", mac_n, mac_cyc); end
    tests++; if (if_n !== 8 || if_first !== 5 || if_last !== 12)
      begin fails++; $display("FAIL cmp_ifmaps: got n=%0d %0d..%0d exp n=8 5..12", if_n, if_first, if_last); end
    tests++; if (done_cyc !== 17) begin fails++; $display("FAIL cmp_done_cyc: got %0d exp 17", done_cyc); end
    tests++; if (done_status !== 32'h0008_0001)
      begin fails++; $display("FAIL cmp_status: got %h exp 00080001", done_status); end
    tests++; if (busy_low_n !== 0 || done_busy !== 0)
      begin fails++; $display("FAIL cmp_busy: got lows=%0d at_done=%0d exp 0 0", busy_low_n, done_busy); end
    tests++; if (kernel_size !== 5'd3 || operation !== 1'b1)
      begin fails++; $display("FAIL cmp_latched: got k=%0d op=%b exp k=3 op=1", kernel_size, operation); end
  endtask

  task automatic test_bad_k();
    logic [4:0] ks [2];
    ks[0] = 5'd0; ks[1] = 5'd6;
    for (int j = 0; j < 2; j++) begin
      issue(INST_COMPUTE, ks[j], 1'b0, 12'h020, 16'd4);
      run_trace(10, 64'h0, -1, 32'h0);
      tests++; if (done_cyc !== 0 || done_status !== 32'h0000_0005)
        begin fails++; $display("FAIL badk%0d_status: got cyc=%0d st=%h exp cyc=0 st=00000005",
          ks[j], done_cyc, done_status); end
      tests++; if (en_n + pre_n + mac_n + if_n !== 0)
        begin fails++; $display("FAIL badk%0d_strobes: got %0d pulses exp 0", ks[j], en_n + pre_n + mac_n + if_n); end
    end
  endtask

  task automatic test_loadifmaps();
    issue(INST_LOADIFMAPS, 5'd2, 1'b0, 12'h100, 16'd5);
    run_trace(40, 64'h1C, -1, 32'h0);
    tests++; if (en_n + pre_n + mac_n !== 0)
      begin fails++; $display("FAIL lif_bram: got %0d weight pulses exp 0", en_n + pre_n + mac_n); end
    tests++; if (if_n !== 5 || pop_empty_n !== 0)
      begin fails++; $display("FAIL lif_pops: got n=%0d while_empty=%0d exp 5 0", if_n, pop_empty_n); end
    tests++; if (if_first !== 0 || if_last !== 7 || done_cyc !== 12)
      begin fails++; $display("FAIL lif_timing: got %0d..%0d done=%0d exp 0..7 done=12", if_first, if_last, done_cyc); end
    tests++; if (done_status !== {16'd5, EXP_PERF, 8'h01})
      begin fails++; $display("FAIL lif_status: got %h exp %h", done_status, {16'd5, EXP_PERF, 8'h01}); end
  endtask

  task automatic test_wrap();
    logic [11:0] exp_a [4];
    exp_a[0] = 12'hFFE; exp_a[1] = 12'hFFF; exp_a[2] = 12'h000; exp_a[3] = 12'h001;
    issue(INST_COMPUTE, 5'd4, 1'b0, 12'hFFE, 16'd2);
    run_trace(40, 64'h0, -1, 32'h0);
    tests++; if (en_n !== 4) begin fails++; $display("FAIL wrap_en_count: got %0d exp 4", en_n); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (addrs[i] !== exp_a[i])
        begin fails++; $display("FAIL wrap_addr%0d: got %h exp %h", i, addrs[i], exp_a[i]); end
    end
    tests++; if (mac_cyc !== 5 || done_status !== 32'h0002_0001)
      begin fails++; $display("FAIL wrap_done: got mac=%0d st=%h exp mac=5 st=00020001", mac_cyc, done_status); end
  endtask

  task automatic test_ignore_midrun();
    issue(INST_COMPUTE, 5'd1, 1'b0, 12'h020, 16'd6);
    run_trace(40, 64'h0, 5, INST_CLEAR);
    tests++; if (if_n !== 6 || done_cyc !== 13)
      begin fails++; $display("FAIL ign_beats: got n=%0d done=%0d exp 6 13", if_n, done_cyc); end
    tests++; if (done_status !== 32'h0006_0001)
      begin fails++; $display("FAIL ign_status: got %h exp 00060001", done_status); end
  endtask

  task automatic test_clear_zero_count();
    issue(INST_CLEAR, 5'd0, 1'b0, 12'h0, 16'd0);
    tests++; if (status !== 32'h0 || busy !== 1'b0)
      begin fails++; $display("FAIL clr_status: got st=%h busy=%b exp 0 0", status, busy); end
    issue(INST_COMPUTE, 5'd2, 1'b0, 12'h040, 16'd0);
    run_trace(40, 64'h0, -1, 32'h0);
    tests++; if (if_n !== 0 || en_n !== 2)
      begin fails++; $display("FAIL zc_pulses: got if=%0d en=%0d exp 0 2", if_n, en_n); end
    tests++; if (done_status !== 32'h0000_0001)
      begin fails++; $display("FAIL zc_status: got %h exp 00000001", done_status); end
  endtask

  task automatic test_reset_midrun();
    issue(INST_COMPUTE, 5'd5, 1'b1, 12'h080, 16'd3);
    ifmaps_fifo_empty = 1'b0;
    #1;
    tests++; if (busy !== 1'b1 || weight_bram_en !== 1'b1)
      begin fails++; $display("FAIL rmr_pre: got busy=%b en=%b exp 1 1", busy, weight_bram_en); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests++; if ({weight_bram_en, load_weight_preload, load_MAC_weight, load_ifmaps, busy} !== 5'b0)
      begin fails++; $display("FAIL rmr_strobes: got %b exp 00000",
        {weight_bram_en, load_weight_preload, load_MAC_weight, load_ifmaps, busy}); end
    tests++; if ({weight_bram_addr, operation, kernel_size} !== 18'h0 || status !== 32'h0)
      begin fails++; $display("FAIL rmr_regs: got %h st=%h exp 0 0", {weight_bram_addr, operation, kernel_size}, status); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0 || weight_bram_en !== 1'b0 || load_weight_preload !== 1'b0)
      begin fails++; $display("FAIL rmr_idle: got busy=%b en=%b pre=%b exp 0 0 0",
        busy, weight_bram_en, load_weight_preload); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; inst = '0; inst_valid = 1'b0; cfg_kernel_size = '0; cfg_operation = 1'b0;
    cfg_weight_base = '0; cfg_ifmap_count = '0; ifmaps_fifo_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_compute();
    test_bad_k();
    test_loadifmaps();
    test_wrap();
    test_ignore_midrun();
    test_clear_zero_count();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_array_sequencer.md
Name: mac_array_sequencer

Overview:
Instruction-driven controller that sequences one MAC array convolution pass, from weight fetch through ifmap streaming to completion.
- Takes an instruction word plus configuration from the AXI-lite register file.
- Generates weight-BRAM read addresses and drives the control strobes of the MAC array control block: load_weight_preload, load_MAC_weight, load_ifmaps, operation, kernel_size.
- Returns a status word that the register file exposes as its reply register (compute over, busy, error, progress).

Parameters:
BRAM_ADDRESS_WIDTH, 12, width of the weight BRAM address.
COUNT_WIDTH, 16, width of the ifmap beat counter and the cfg_ifmap_count field.
DRAIN_CYCLES, 4, cycles waited after the last ifmap beat so in-flight psums settle.

Ports:
clk  input  1  single system clock
rst_n  input  1  synchronous, active-low reset
inst  input  32  instruction word: 87 = COMPUTE, 88 = LOADIFMAPS, 0 = CLEAR
inst_valid  input  1  one-cycle strobe qualifying inst
cfg_kernel_size  input  5  kernel size K; legal range 1..5
cfg_operation  input  1  operation select, passed through to the MAC array
cfg_weight_base  input  BRAM_ADDRESS_WIDTH  first weight row address
cfg_ifmap_count  input  COUNT_WIDTH  number of ifmap beats to stream; 0 is legal
ifmaps_fifo_empty  input  1  ifmap FIFO empty flag
weight_bram_addr  output  BRAM_ADDRESS_WIDTH  weight BRAM read address
weight_bram_en  output  1  weight BRAM read enable
load_weight_preload  output  1  one pulse per weight row
load_MAC_weight  output  1  commits preloaded weights into the MACs
load_ifmaps  output  1  ifmap beat accepted; equals a FIFO pop
operation  output  1  registered copy of cfg_operation
kernel_size  output  5  registered copy of cfg_kernel_size
busy  output  1  high whenever state is not IDLE or DONE
status  output  32  [0] done, [1] busy, [2] err, [7:3] reserved 0, [15:8] perf field, [31:16] beats consumed

Behaviour:
- Reset: on rst_n=0 at a clk edge, go to IDLE and clear every output, the status word and all counters to 0.
- The config inputs, operation and kernel_size are latched only when an instruction is accepted.

Instruction acceptance:
- inst_valid is honoured only in IDLE or DONE.
- inst_valid in any other state is ignored; it is not queued.
- COMPUTE: if K is 0 or greater than 5, set err=1 and go to DONE with done=1; no strobes are issued. Otherwise latch the config and go to LOAD_WT.
- LOADIFMAPS: latch the config and go straight to COMPUTE, reusing the weights already in the MACs. The K check is skipped.
- CLEAR: clear done, err and beats consumed, then go to IDLE.
- Any other opcode: no effect.

LOAD_WT:
- Row counter r runs 0..K-1.
- On each cycle r: weight_bram_en=1 and weight_bram_addr = cfg_weight_base + r, computed modulo 2^BRAM_ADDRESS_WIDTH (address wraps).
- BRAM read latency is 1 cycle, so load_weight_preload pulses in the cycle after each enable. That gives K pulses on consecutive cycles.
- After the last pulse, go to COMMIT.

COMMIT:
- Drive load_MAC_weight=1 for exactly 1 cycle, then go to COMPUTE.
- Ordering: the first enable and load_MAC_weight are exactly K+1 cycles apart.

COMPUTE:
- load_ifmaps = !ifmaps_fifo_empty while beats consumed < cfg_ifmap_count. This is a combinational gate on the registered state.
- Each asserted cycle increments beats consumed.
- When beats consumed reaches cfg_ifmap_count, go to DRAIN. load_ifmaps must never exceed the count.
- If cfg_ifmap_count is 0, go directly to DRAIN.

DRAIN:
- Count DRAIN_CYCLES cycles, then go to DONE.

DONE:
- done=1 and busy=0.
- Status is held until a new instruction arrives. A COMPUTE or LOADIFMAPS issued from DONE clears done and err at acceptance.

Other rules:
- Beats consumed saturates at all-ones.
- Reset mid-sequence aborts immediately: all strobes go to 0 in the cycle after reset is sampled.

Optional Feature:
Macro MAC_SEQ_PERF_CNT_EN.
- Defined: status[15:8] is an 8-bit saturating count of cycles spent in COMPUTE with ifmaps_fifo_empty=1 while beats remain. It clears at instruction acceptance and on CLEAR.
- Undefined: status[15:8] is tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared package: opcode constants (INST_COMPUTE=87, INST_LOADIFMAPS=88, INST_CLEAR=0), the state encoding (IDLE, LOAD_WT, COMMIT, COMPUTE, DRAIN, DONE), status bit index constants, and KERNEL_MAX=5.
- One natural sub-module, mac_seq_weight_fetch: generates the BRAM addresses/enables and the delayed preload pulses, and returns a one-cycle fetch_done flag.

Test Plan:
- COMPUTE with K=3, base=0x010, count=8, FIFO never empty:
  - en high on 3 cycles with addr 0x010, 0x011, 0x012.
  - 3 preload pulses, each 1 cycle later.
  - load_MAC_weight 1 cycle after the last preload.
  - 8 load_ifmaps cycles, then 4 drain cycles, then done=1 and status[31:16]=8.
- COMPUTE with K=0 and with K=6 → no strobes; status = 0x5 (done and err set).
- LOADIFMAPS with count=5 and the FIFO empty on 3 cycles mid-stream:
  - No BRAM activity.
  - Exactly 5 load_ifmaps pulses, none while empty.
  - With MAC_SEQ_PERF_CNT_EN defined, status[15:8]=3; without it, 0.
- Base=0xFFE, K=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Mid-run behaviour:
  - inst_valid asserted during COMPUTE is ignored and beats are unaffected.
  - rst_n=0 asserted during LOAD_WT → all outputs are 0 in the cycle after reset is sampled; state is IDLE.
- After done, CLEAR → status=0; then COMPUTE with count=0 completes via DRAIN with zero load_ifmaps pulses.
